// File: rtl/mul_add_acc.sv
// mul_add_acc: pipelined unsigned multiply-add with a running accumulator.
//
// Computes P = X*Y + base, where base is A (acc_i=0), 0 (acc_i=1, clr_i=1)
// or the accumulator (acc_i=1, clr_i=0). Latency is STAGES cycles with a
// valid/ready handshake on both sides. Back-pressure stalls the pipeline as a
// whole. The add and the accumulator update live in the final stage, so
// back-to-back accumulate beats chain without hazards.
//
// Optional build macro: MUL_ADD_ACC_SATURATE_EN. When defined, a carry-out
// saturates P and the accumulator to all ones. Otherwise the sum wraps.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   in_valid_i   input beat valid
//   in_ready_o   input beat accepted when in_valid_i is also high
//   X, Y         unsigned multiplier / multiplicand
//   A            augend used when acc_i=0
//   acc_i        select accumulator as the base operand
//   clr_i        with acc_i=1, use 0 as the base operand
//   out_valid_o  result valid
//   out_ready_i  downstream accepts the result
//   P            result
//   ovf_o        carry-out of the final addition
module mul_add_acc #(
  parameter int unsigned BW     = 8,
  parameter int unsigned widthX = BW,
  parameter int unsigned widthY = BW,
  parameter int unsigned widthA = 2 * BW,
  parameter int unsigned STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [widthX-1:0] X,
  input  logic [widthY-1:0] Y,
  input  logic [widthA-1:0] A,
  input  logic              acc_i,
  input  logic              clr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [widthA-1:0] P,
  output logic              ovf_o
);

  localparam int unsigned WP = widthX + widthY;

  typedef struct packed {
    logic              vld;
    logic [WP-1:0]     prod;
    logic [widthA-1:0] a;
    logic              acc;
    logic              clr;
  } beat_t;

  logic              advance;
  beat_t             in_beat;
  beat_t             head;

  logic              out_valid_q, out_valid_d;
  logic [widthA-1:0] p_q, p_d;
  logic [widthA-1:0] acc_q, acc_d;
  logic              ovf_q, ovf_d;

  logic [widthA:0]   prod_ext;
  logic [widthA:0]   base_ext;
  logic [widthA:0]   sum;
  logic [widthA-1:0] res;

  // Whole-pipeline stall: everything moves only when the output slot frees up.
  always_comb begin
    advance    = out_ready_i | ~out_valid_q;
    in_ready_o = advance;
  end

  // Product formed before the first register; operands zero-extended to the
  // full product width so no bits are lost.
  always_comb begin
    in_beat.vld  = in_valid_i;
    in_beat.prod = {{widthY{1'b0}}, X} * {{widthX{1'b0}}, Y};
    in_beat.a    = A;
    in_beat.acc  = acc_i;
    in_beat.clr  = clr_i;
  end

  // Stages 1..STAGES-1 carry the beat; the output register is the last stage.
  if (STAGES == 1) begin : g_direct
    assign head = in_beat;
  end else begin : g_pipe
    beat_t pipe_q [STAGES-1];
    beat_t pipe_d [STAGES-1];

    always_comb begin
      pipe_d = pipe_q;
      if (advance) begin
        pipe_d[0] = in_beat;
        for (int unsigned i = 1; i < STAGES - 1; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < STAGES - 1; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign head = pipe_q[STAGES-2];
  end

  // Final stage: base select, widened add, optional saturation.
  always_comb begin
    prod_ext           = '0;
    prod_ext[WP-1:0]   = head.prod;
    base_ext           = '0;
    if (!head.acc) begin
      base_ext[widthA-1:0] = head.a;
    end else if (!head.clr) begin
      base_ext[widthA-1:0] = acc_q;
    end
    sum = prod_ext + base_ext;
    res = sum[widthA-1:0];
`ifdef MUL_ADD_ACC_SATURATE_EN
    if (sum[widthA]) begin
      res = '1;
    end
`else
`endif

    out_valid_d = out_valid_q;
    p_d         = p_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    if (advance) begin
      out_valid_d = head.vld;
      // Bubbles leave P and the accumulator untouched.
      if (head.vld) begin
        p_d   = res;
        ovf_d = sum[widthA];
        acc_d = res;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      p_q         <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      p_q         <= p_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign P           = p_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_mul_add_acc.sv
// Scoreboard bench for mul_add_acc. Three instances (STAGES=2, 1, 4) share
// the input bus; the STAGES=2 instance gets the directed tests, all three get
// the random sweep. The driver pushes expected results, the monitor pops them.
module tb_mul_add_acc;

  typedef struct {
    logic [15:0] p;
    logic        ovf;
    int          t;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_valid_s;
  logic [7:0]  x, y;
  logic [15:0] a;
  logic        acc, clr;
  logic        out_ready;

  logic        ir  [3];
  logic        ov  [3];
  logic [15:0] p   [3];
  logic        ovf [3];

  int          stg_of [3] = '{2, 1, 4};
  exp_t        sb [3][$];
  logic [15:0] mdl [3];

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          rst_d = 1'b0;
  bit          stall_prev [3] = '{0, 0, 0};
  logic [15:0] p_prev [3];
  bit          drain_req = 1'b0;
  bit          drain_done = 1'b0;
  int          drv_miss = 0;
  exp_t        e;

  always #5 clk = ~clk;

  mul_add_acc #(.BW(8), .STAGES(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(ir[0]),
    .X(x), .Y(y), .A(a), .acc_i(acc), .clr_i(clr),
    .out_valid_o(ov[0]), .out_ready_i(out_ready), .P(p[0]), .ovf_o(ovf[0])
  );

  mul_add_acc #(.BW(8), .STAGES(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_s), .in_ready_o(ir[1]),
    .X(x), .Y(y), .A(a), .acc_i(acc), .clr_i(clr),
    .out_valid_o(ov[1]), .out_ready_i(out_ready), .P(p[1]), .ovf_o(ovf[1])
  );

  mul_add_acc #(.BW(8), .STAGES(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_s), .in_ready_o(ir[2]),
    .X(x), .Y(y), .A(a), .acc_i(acc), .clr_i(clr),
    .out_valid_o(ov[2]), .out_ready_i(out_ready), .P(p[2]), .ovf_o(ovf[2])
  );

  function automatic logic [16:0] golden(input logic [7:0] gx, input logic [7:0] gy,
                                         input logic [15:0] ga, input bit gacc,
                                         input bit gclr, input logic [15:0] accst);
    logic [16:0] s;
    logic [15:0] base;
    base = gacc ? (gclr ? 16'h0000 : accst) : ga;
    s = 17'(gx) * 17'(gy) + 17'(base);
`ifdef MUL_ADD_ACC_SATURATE_EN
    if (s[16]) s[15:0] = 16'hFFFF;
`else
`endif
    return s;
  endfunction

  task automatic chk(input string name, input int d, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (STAGES=%0d) at cycle %0d: got %0h, expected %0h",
               name, stg_of[d], cyc, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  // Monitor: reset/stall properties plus in-order result comparison.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst_d) begin
        chk("reset_out_valid", d, int'(ov[d]), 0);
        chk("reset_in_ready", d, int'(ir[d]), 1);
      end else begin
        if (stall_prev[d]) begin
          chk("stall_hold_valid", d, int'(ov[d]), 1);
          chk("stall_hold_p", d, int'(p[d]), int'(p_prev[d]));
        end
        if (ov[d] && !out_ready) chk("stall_in_ready", d, int'(ir[d]), 0);
        if (ov[d] && out_ready) begin
          chk("output_expected", d, int'(sb[d].size() != 0), 1);
          if (sb[d].size() != 0) begin
            e = sb[d].pop_front();
            chk("P", d, int'(p[d]), int'(e.p));
            chk("ovf", d, int'(ovf[d]), int'(e.ovf));
            if (e.lat) chk("latency", d, cyc - e.t, stg_of[d]);
          end
        end
      end
      stall_prev[d] <= ov[d] && !out_ready;
      p_prev[d]     <= p[d];
    end
    if (drain_req && !drain_done) begin
      chk("drain_empty", 0, sb[0].size() + sb[1].size() + sb[2].size() + drv_miss, 0);
      drain_done <= 1'b1;
    end
  end

  task automatic send(input logic [7:0] sx, input logic [7:0] sy, input logic [15:0] sa,
                      input bit sacc, input bit sclr, input bit all3, input bit lat);
    logic [16:0] r;
    bit          ok;
    exp_t        ent;
    x = sx; y = sy; a = sa; acc = sacc; clr = sclr;
    in_valid = 1'b1;
    in_valid_s = all3;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ir[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      drv_miss++;
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (d == 0 || all3) begin
          r = golden(sx, sy, sa, sacc, sclr, mdl[d]);
          mdl[d] = r[15:0];
          ent.p = r[15:0]; ent.ovf = r[16]; ent.t = cyc; ent.lat = lat;
          sb[d].push_back(ent);
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_valid_s = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_valid_s = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; a = '0; acc = 1'b0; clr = 1'b0;
    for (int d = 0; d < 3; d++) mdl[d] = 16'h0000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Full-scale product plus augend, no carry; then the carry case.
    send(8'd255, 8'd255, 16'h01FE, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    send(8'd255, 8'd255, 16'h01FF, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back accumulate: 6, 12, 18.
    send(8'd2, 8'd3, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
    send(8'd2, 8'd3, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    send(8'd2, 8'd3, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // Six-beat stream with a five-cycle output stall in the middle.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(8'(i + 1), 8'd10, 16'(i * 3), 1'b0, 1'b0, 1'b0, 1'b0);
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;

    // Two beats held in flight by back-pressure, then reset; junk input
    // during reset must be ignored.
    out_ready = 1'b0;
    send(8'd7, 8'd7, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'd9, 8'd9, 16'h4321, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1; x = 8'd99; y = 8'd99; a = 16'h5555; acc = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int d = 0; d < 3; d++) begin
      sb[d].delete();
      mdl[d] = 16'h0000;
    end
    // Accumulator restarted at 0 by reset.
    send(8'd2, 8'd3, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // Random sweep on all three latencies, with occasional bubbles.
    for (int i = 0; i < 24; i++) begin
      send(8'($urandom), 8'($urandom), 16'($urandom), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), 1'b1, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    for (int i = 0; i < 200 && (sb[0].size() + sb[1].size() + sb[2].size()) != 0; i++) begin
      @(negedge clk);
    end
    drain_req = 1'b1;
    for (int i = 0; i < 10 && !drain_done; i++) @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
